// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline stages.
// Control-bundle bit positions and the memory-port state type.
package mips_pkg;

    localparam int M_BRANCH    = 2;
    localparam int M_READ      = 1;
    localparam int M_WRITE     = 0;

    localparam int WB_MEM2REG  = 1;
    localparam int WB_REGWRITE = 0;

    typedef enum logic {
        IDLE,
        REQ
    } mem_state_t;

endpackage

// File: rtl/dmem_port_ctrl.sv
// Data-memory request/acknowledge port controller.
// Owns the access FSM, wait counter, dmem_* registers and the stall.
module dmem_port_ctrl
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        start_we,
    input  logic [31:0] start_addr,
    input  logic [31:0] start_wdata,
    input  logic        dmem_ack,
    output logic        busy,
    output logic        done,
    output logic        expire,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic        bus_err
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    mem_state_t state;
    mem_state_t state_nx;
    logic [7:0] cnt;
    logic       last;

    assign last = (cnt == CNT_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: leave REQ on ack or when the wait budget is spent
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = REQ;
            REQ:  if (dmem_ack || last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs: stall released in the cycle the access resolves; low in reset
    always_comb begin
        busy   = (state == REQ);
        done   = busy & dmem_ack;
        expire = busy & ~dmem_ack & last;
        if (busy) begin
            stall = rst_n & ~(dmem_ack | last);
        end else begin
            stall = rst_n & start;
        end
    end

    // Request registers, wait counter and bus-error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            bus_err    <= 1'b0;
            cnt        <= '0;
        end else begin
            bus_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= start_we;
                        dmem_addr  <= start_addr;
                        dmem_wdata <= start_wdata;
                        cnt        <= '0;
                    end
                end
                REQ: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                    end else if (last) begin
                        dmem_req <= 1'b0;
                        bus_err  <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: dmem_req <= 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/mem_access.sv
// MEM stage: branch resolve, alignment check and the MEM/WB register.
// Memory handshaking is delegated to dmem_port_ctrl.
module mem_access
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] res,
    input  logic [31:0] write_data_ex,
    input  logic [4:0]  write_register,
    input  logic        zero,
    input  logic [2:0]  m_MEM,
    input  logic [1:0]  wb_MEM,
    output logic        pc_src,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [31:0] read_data_wb,
    output logic [31:0] alu_res_wb,
    output logic [4:0]  write_register_wb,
    output logic [1:0]  wb_WB,
    output logic        bus_err,
    output logic        misalign
);

    logic is_acc;
    logic is_load;
    logic mis;
    logic start;
    logic busy;
    logic done;
    logic expire;
    logic waiting;

    assign is_acc  = m_MEM[M_READ] | m_MEM[M_WRITE];
    assign is_load = m_MEM[M_READ] & ~m_MEM[M_WRITE];
    assign mis     = is_acc & (res[1:0] != 2'b00);
    assign start   = is_acc & ~mis;
    assign waiting = busy & ~done & ~expire;
    assign pc_src  = m_MEM[M_BRANCH] & zero & ~stall;

    dmem_port_ctrl #(
        .TIMEOUT(TIMEOUT)
    ) u_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_we   (m_MEM[M_WRITE]),
        .start_addr (res),
        .start_wdata(write_data_ex),
        .dmem_ack   (dmem_ack),
        .busy       (busy),
        .done       (done),
        .expire     (expire),
        .stall      (stall),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .bus_err    (bus_err)
    );

    // MEM/WB register: real result, squashed result, or bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_data_wb      <= '0;
            alu_res_wb        <= '0;
            write_register_wb <= '0;
            wb_WB             <= '0;
            misalign          <= 1'b0;
        end else begin
            misalign <= 1'b0;
            unique case (1'b1)
                done: begin
                    alu_res_wb        <= res;
                    write_register_wb <= write_register;
                    wb_WB             <= wb_MEM;
                    if (is_load) read_data_wb <= dmem_rdata;
                end
                expire: begin
                    alu_res_wb        <= res;
                    write_register_wb <= write_register;
                    wb_WB             <= 2'b00;
                end
                waiting: begin
                    wb_WB <= 2'b00;
                end
                (~busy & mis): begin
                    alu_res_wb        <= res;
                    write_register_wb <= write_register;
                    wb_WB             <= 2'b00;
                    misalign          <= 1'b1;
                end
                (~busy & start): begin
                    wb_WB <= 2'b00;
                end
                (~busy & ~is_acc): begin
                    alu_res_wb        <= res;
                    write_register_wb <= write_register;
                    wb_WB             <= wb_MEM;
                end
                default: wb_WB <= 2'b00;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with a four-cycle memory timeout.
// Inputs change 1 time unit after the rising edge; outputs sampled there.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] res;
    logic [31:0] write_data_ex;
    logic [4:0]  write_register;
    logic        zero;
    logic [2:0]  m_MEM;
    logic [1:0]  wb_MEM;
    logic        pc_src;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic [31:0] read_data_wb;
    logic [31:0] alu_res_wb;
    logic [4:0]  write_register_wb;
    logic [1:0]  wb_WB;
    logic        bus_err;
    logic        misalign;

    int n_chk  = 0;
    int n_pass = 0;
    int stalls;
    int reqs;

    always #5 clk = ~clk;

    mem_access #(.TIMEOUT(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .res              (res),
        .write_data_ex    (write_data_ex),
        .write_register   (write_register),
        .zero             (zero),
        .m_MEM            (m_MEM),
        .wb_MEM           (wb_MEM),
        .pc_src           (pc_src),
        .stall            (stall),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_rdata       (dmem_rdata),
        .dmem_ack         (dmem_ack),
        .read_data_wb     (read_data_wb),
        .alu_res_wb       (alu_res_wb),
        .write_register_wb(write_register_wb),
        .wb_WB            (wb_WB),
        .bus_err          (bus_err),
        .misalign         (misalign)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        res            = '0;
        write_data_ex  = '0;
        write_register = '0;
        zero           = 1'b0;
        m_MEM          = 3'b000;
        wb_MEM         = 2'b00;
        dmem_rdata     = '0;
        dmem_ack       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", dmem_req, 0);
        chk("rst_stall", stall, 0);
        chk("rst_wb", wb_WB, 0);
        chk("rst_alu", alu_res_wb, 0);
        chk("rst_rd", read_data_wb, 0);
        chk("rst_err", {bus_err, misalign}, 0);
        rst_n = 1'b1;

        // ALU op
        res            = 32'h24;
        wb_MEM         = 2'b01;
        write_register = 5'd5;
        #1 chk("alu_stall", stall, 0);
        tick();
        chk("alu_res", alu_res_wb, 32'h24);
        chk("alu_wb", wb_WB, 2'b01);
        chk("alu_wr", write_register_wb, 5);
        chk("alu_stall2", stall, 0);

        // Branch resolve
        m_MEM = 3'b100;
        zero  = 1'b1;
        #1 chk("br_taken", pc_src, 1);
        zero = 1'b0;
        #1 chk("br_not", pc_src, 0);

        // Load, ack three cycles after request
        res            = 32'h100;
        m_MEM          = 3'b010;
        wb_MEM         = 2'b11;
        write_register = 5'd8;
        dmem_rdata     = 32'hDEADBEEF;
        stalls         = 0;
        #1 stalls += int'(stall);
        tick();
        chk("ld_req", dmem_req, 1);
        chk("ld_addr", dmem_addr, 32'h100);
        chk("ld_we", dmem_we, 0);
        chk("ld_bubble", wb_WB, 0);
        stalls += int'(stall);
        tick();
        stalls += int'(stall);
        tick();
        stalls += int'(stall);
        chk("ld_bubble2", wb_WB, 0);
        tick();
        dmem_ack = 1'b1;
        #1 stalls += int'(stall);
        chk("ld_ack_stall", stall, 0);
        tick();
        dmem_ack = 1'b0;
        chk("ld_stalls", stalls, 4);
        chk("ld_data", read_data_wb, 32'hDEADBEEF);
        chk("ld_wb", wb_WB, 2'b11);
        chk("ld_alu", alu_res_wb, 32'h100);
        chk("ld_reqoff", dmem_req, 0);
        m_MEM = 3'b000;

        // Store, zero-wait
        res           = 32'h40;
        write_data_ex = 32'h12345678;
        m_MEM         = 3'b001;
        wb_MEM        = 2'b00;
        stalls        = 0;
        #1 stalls += int'(stall);
        tick();
        chk("st_we", dmem_we, 1);
        chk("st_wdata", dmem_wdata, 32'h12345678);
        chk("st_addr", dmem_addr, 32'h40);
        dmem_ack = 1'b1;
        #1 stalls += int'(stall);
        tick();
        dmem_ack = 1'b0;
        m_MEM    = 3'b000;
        chk("st_stalls", stalls, 1);
        chk("st_rd_hold", read_data_wb, 32'hDEADBEEF);
        chk("st_reqoff", dmem_req, 0);

        // Timeout: never acknowledged
        res    = 32'h200;
        m_MEM  = 3'b010;
        wb_MEM = 2'b11;
        tick();
        reqs = 0;
        while (dmem_req && reqs < 10) begin
            reqs++;
            if (reqs == 4) chk("to_last_stall", stall, 0);
            tick();
        end
        chk("to_reqs", reqs, 4);
        chk("to_buserr", bus_err, 1);
        chk("to_wb", wb_WB, 0);
        m_MEM = 3'b000;
        tick();
        chk("to_pulse", bus_err, 0);

        // Misaligned load
        res   = 32'h102;
        m_MEM = 3'b010;
        #1 chk("mis_stall", stall, 0);
        tick();
        chk("mis_pulse", misalign, 1);
        chk("mis_req", dmem_req, 0);
        chk("mis_wb", wb_WB, 0);
        chk("mis_alu", alu_res_wb, 32'h102);
        m_MEM = 3'b000;
        tick();
        chk("mis_end", misalign, 0);

        // Reset mid-request, then the held load completes
        res        = 32'h300;
        m_MEM      = 3'b010;
        wb_MEM     = 2'b11;
        dmem_rdata = 32'hCAFEF00D;
        tick();
        tick();
        chk("rr_req", dmem_req, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rr_req0", dmem_req, 0);
        chk("rr_stall0", stall, 0);
        chk("rr_wb0", wb_WB, 0);
        chk("rr_rd0", read_data_wb, 0);
        #2 rst_n = 1'b1;
        tick();
        chk("rr_req2", dmem_req, 1);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        m_MEM    = 3'b000;
        chk("rr_data", read_data_wb, 32'hCAFEF00D);
        chk("rr_wb", wb_WB, 2'b11);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the five-stage MIPS pipeline: the consumer of the EX/MEM pipeline register. It resolves branches from the EX `zero` flag, performs word loads/stores through a variable-latency request/acknowledge data-memory port, stalls the front of the pipeline while an access is outstanding, and drives the MEM/WB pipeline register read by write-back and the forwarding unit.

## Interface
- `TIMEOUT`, 16: maximum cycles `dmem_req` waits for `dmem_ack` before aborting; legal range 2..255.
- `clk` in 1: pipeline clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `res` in 32: ALU result from EX; the memory address for loads and stores, otherwise forwarded to WB.
- `write_data_ex` in 32: store data (rt value).
- `write_register` in 5: destination register.
- `zero` in 1: ALU zero flag.
- `m_MEM` in 3: {branch, mem_read, mem_write} in bits [2], [1], [0].
- `wb_MEM` in 2: {mem_to_reg, reg_write} in bits [1], [0].
- `pc_src` out 1: combinational `m_MEM[2] & zero`; forced to 0 while `stall` is 1.
- `stall` out 1: combinational; freezes PC, IF/ID, ID/EX and EX/MEM when 1.
- `dmem_req` out 1: registered access request.
- `dmem_we` out 1: registered; 1 = store.
- `dmem_addr` out 32: registered word address.
- `dmem_wdata` out 32: registered store data.
- `dmem_rdata` in 32: load data, valid when `dmem_ack` is 1.
- `dmem_ack` in 1: single-cycle completion strobe.
- `read_data_wb` out 32: registered load data.
- `alu_res_wb` out 32: registered `res`.
- `write_register_wb` out 5: registered destination.
- `wb_WB` out 2: registered WB control.
- `bus_err` out 1: registered one-cycle pulse on timeout.
- `misalign` out 1: registered one-cycle pulse on unaligned access.

## Operation
- States: IDLE, REQ.
- IDLE, no access (`m_MEM[1:0]==0`): MEM/WB loads `res`, `write_register`, `wb_MEM`; `read_data_wb` holds its value; `stall=0`.
- IDLE, access with `res[1:0]!=0`: no request, `stall=0`, `misalign` pulses; MEM/WB loads with `wb_WB=2'b00`.
- IDLE, aligned access: `stall=1`; MEM/WB loads a bubble (`wb_WB=0`, other fields hold); next state REQ with `dmem_req=1`, `dmem_we=m_MEM[0]`, `dmem_addr=res`, `dmem_wdata=write_data_ex`; wait counter cleared.
- `mem_read` and `mem_write` both set is treated as a store.
- REQ: address, data and `dmem_we` stay stable while `dmem_req=1`.
  - If `dmem_ack=1`: `stall=0` in that cycle; at the edge, `dmem_req` clears, MEM/WB loads `dmem_rdata` (loads only; stores leave `read_data_wb` unchanged), `res`, `write_register` and `wb_MEM`; next state IDLE.
  - If no ack, the counter increments. When the counter equals `TIMEOUT-1` without an ack: `stall=0`; at the edge, `dmem_req` clears, `bus_err` pulses, MEM/WB loads with `wb_WB=0`; next state IDLE.
  - Otherwise `stall=1`, MEM/WB loads a bubble, and the state stays REQ.
- `dmem_ack` in IDLE is ignored.
- Upstream inputs are held constant while `stall=1`; the block relies on this.

## Timing
- Reset (async, `rst_n=0`): state IDLE, all registered outputs 0, counter 0. Reset during REQ drops `dmem_req` immediately; the access is abandoned.
- Non-memory instruction: 1-cycle stage latency, no stall.
- Aligned access with zero-wait memory: cycle N is IDLE with `stall=1`; cycle N+1 is `dmem_req=1`, `dmem_ack=1`, `stall=0`; MEM/WB is valid after the N+1 edge. Total latency is 2 cycles with 1 stall cycle.
- Ack k cycles after `dmem_req` rises (k<`TIMEOUT`): k+1 stall cycles.
- Timeout: `dmem_req` is high for exactly `TIMEOUT` cycles; `bus_err` is high the cycle after.
- Back-to-back accesses: the next access is seen in IDLE the cycle after the ack edge. `dmem_req` is low for at least 1 cycle between requests.

## Structure
- Shared package `mips_pkg`:
  - M bit indices `M_BRANCH=2`, `M_READ=1`, `M_WRITE=0`.
  - WB bit indices `WB_MEM2REG=1`, `WB_REGWRITE=0`.
  - `typedef enum logic {IDLE, REQ} mem_state_t`.
- Sub-module `dmem_port_ctrl`: FSM, wait counter, `dmem_*` registers, `stall`, `bus_err`. The top level holds branch logic, misalignment check and the MEM/WB register.

## Test plan
- ALU op: `res=0x24`, `wb_MEM=2'b01`, `m_MEM=0` -> next cycle `alu_res_wb=0x24`, `wb_WB=2'b01`, `stall` never high.
- Branch: `m_MEM=3'b100`, `zero=1` -> `pc_src=1` in the same cycle; with `zero=0` -> `pc_src=0`.
- Load, ack 3 cycles after req: `res=0x100`, `m_MEM=3'b010`, `wb_MEM=2'b11`, `dmem_rdata=0xDEADBEEF` -> `stall` high 4 cycles, `dmem_addr=0x100`, `dmem_we=0`, then `read_data_wb=0xDEADBEEF`, `wb_WB=2'b11`; `wb_WB=0` during the stall.
- Store, zero-wait: `res=0x40`, `write_data_ex=0x12345678`, `m_MEM=3'b001` -> `dmem_we=1`, `dmem_wdata=0x12345678`, exactly 1 stall cycle.
- Timeout with `TIMEOUT=4`, ack never asserted -> `dmem_req` high 4 cycles, then `bus_err` pulses 1 cycle, `wb_WB=0`, state IDLE; a load to `0x102` -> `misalign` pulse, no `dmem_req`, no stall.
- Assert `rst_n=0` mid-REQ -> `dmem_req`, `stall`, `wb_WB` 0 immediately without a clock edge; a following load completes normally.
